// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: active-low row strobe, column sync,
// frame-based debounce and one-cycle key_valid strobe per new press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0] STB_MAX = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] STB_ARM = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ONE,
    CLS_MULTI
  } cls_e;

  typedef enum logic {
    RELEASED,
    PRESSED
  } state_e;

  logic [CW-1:0]   cnt;
  logic [1:0]      row_idx;
  logic [3:0]      col_meta;
  logic [3:0]      col_sync;
  logic [2:0][3:0] acc;
  cls_e            prev_cls;
  logic [3:0]      prev_code;
  logic [3:0]      stable_cnt;
  state_e          state;
  state_e          state_nxt;

  logic        sample;
  logic        frame_done;
  logic [15:0] frame;
  logic        one_seen;
  logic        many;
  logic [3:0]  code;
  cls_e        cls;
  logic [3:0]  cls_code;
  logic        same;
  logic [3:0]  stable_nxt;
  logic        act;

  logic [3:0] code_nxt;
  logic       valid_nxt;
  logic       held_nxt;

  assign sample     = (cnt == CNT_MAX);
  assign frame_done = sample && (row_idx == 2'd3);
  // Row 3 is classified straight from the synchroniser on its sample cycle.
  assign frame      = {~col_sync, acc};

  always_comb begin
    one_seen = 1'b0;
    many     = 1'b0;
    code     = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame[i]) begin
        if (one_seen) many = 1'b1;
        one_seen = 1'b1;
        code     = 4'(i);
      end
    end
  end

  always_comb begin
    cls      = CLS_NONE;
    cls_code = 4'd0;
    if (many) begin
      cls = CLS_MULTI;
    end else if (one_seen) begin
      cls      = CLS_ONE;
      cls_code = code;
    end
  end

  assign same = (cls == prev_cls) && (cls_code == prev_code);
  assign act  = same && (stable_cnt == STB_ARM);

  always_comb begin
    stable_nxt = 4'd1;
    if (same) begin
      if (stable_cnt == STB_MAX) stable_nxt = stable_cnt;
      else stable_nxt = stable_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      row_idx  <= 2'd0;
      row_out  <= 4'b1110;
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
      acc      <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      if (sample) begin
        cnt     <= '0;
        row_idx <= row_idx + 2'd1;
        row_out <= ~(4'b0001 << (row_idx + 2'd1));
        if (row_idx != 2'd3) acc[row_idx] <= ~col_sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_cls   <= CLS_NONE;
      prev_code  <= 4'd0;
      stable_cnt <= 4'd0;
    end else if (frame_done) begin
      prev_cls   <= cls;
      prev_code  <= cls_code;
      stable_cnt <= stable_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RELEASED;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  // Actions fire only on the frame where the count first saturates.
  always_comb begin
    state_nxt = state;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    if (frame_done && act) begin
      unique case (state)
        RELEASED: begin
          if (cls == CLS_ONE) begin
            code_nxt  = cls_code;
            valid_nxt = 1'b1;
            held_nxt  = 1'b1;
            state_nxt = PRESSED;
          end
        end
        PRESSED: begin
          if (cls == CLS_ONE && cls_code != key_code) begin
            code_nxt  = cls_code;
            valid_nxt = 1'b1;
          end else if (cls == CLS_NONE) begin
            held_nxt  = 1'b0;
            state_nxt = RELEASED;
          end
        end
        default: state_nxt = RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=3
// (32-cycle frames); a key-mask model drives the columns.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] mask = 16'h0000;

  int vecs = 0;
  int errs = 0;
  int pulses = 0;
  int base = 0;

  keypad_scanner #(
    .SCAN_DIV(8),
    .DEBOUNCE_SCANS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col_in(col_in),
    .row_out(row_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to its row when that row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && mask[r*4+c]) col_in[c] = 1'b0;
  end

  always @(negedge clk)
    if (key_valid === 1'b1) pulses <= pulses + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] rows [4];
    rows[0] = 4'b1101;
    rows[1] = 4'b1011;
    rows[2] = 4'b0111;
    rows[3] = 4'b1110;
    mask = 16'h0;
    #23 rst = 1'b1;
    #1;
    vecs++;
    if ({row_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 2'b00}) begin
      errs++;
      $display("FAIL reset_outputs: got row=%b code=%0d v=%b h=%b expected row=1110 code=0 v=0 h=0",
               row_out, key_code, key_valid, key_held);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(7);
    vecs++;
    if (row_out !== 4'b1110) begin
      errs++;
      $display("FAIL row_hold_7: got %b expected 1110", row_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i == 0 ? 1 : 8);
      vecs++;
      if (row_out !== rows[i] || key_valid !== 1'b0 || key_held !== 1'b0) begin
        errs++;
        $display("FAIL row_step_%0d: got row=%b v=%b h=%b expected row=%b v=0 h=0",
                 i, row_out, key_valid, key_held, rows[i]);
      end
    end
  endtask

  task automatic test_single_press();
    mask = 16'h0200;
    do_reset();
    base = pulses;
    tick(95);
    vecs++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      errs++;
      $display("FAIL press_early: got v=%b h=%b expected v=0 h=0", key_valid, key_held);
    end
    tick(1);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd9, 1'b1}) begin
      errs++;
      $display("FAIL press_pulse: got v=%b code=%0d h=%b expected v=1 code=9 h=1",
               key_valid, key_code, key_held);
    end
    tick(1);
    vecs++;
    if (key_valid !== 1'b0) begin
      errs++;
      $display("FAIL press_one_cycle: got v=%b expected 0", key_valid);
    end
    tick(320);
    vecs++;
    if (pulses - base != 1 || key_held !== 1'b1 || key_code !== 4'd9) begin
      errs++;
      $display("FAIL press_hold: got pulses=%0d h=%b code=%0d expected pulses=1 h=1 code=9",
               pulses - base, key_held, key_code);
    end
  endtask

  task automatic test_bounce();
    mask = 16'h0;
    do_reset();
    base = pulses;
    for (int f = 1; f <= 12; f++) begin
      mask = (f % 2 == 1) ? 16'h0200 : 16'h0000;
      tick(32);
      vecs++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
        errs++;
        $display("FAIL bounce_frame_%0d: got v=%b h=%b expected v=0 h=0", f, key_valid, key_held);
      end
    end
    tick(1);
    vecs++;
    if (pulses - base != 0) begin
      errs++;
      $display("FAIL bounce_pulses: got %0d expected 0", pulses - base);
    end
  endtask

  task automatic test_rollover();
    mask = 16'h0001;
    do_reset();
    base = pulses;
    tick(96);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd0, 1'b1}) begin
      errs++;
      $display("FAIL roll_first: got v=%b code=%0d h=%b expected v=1 code=0 h=1",
               key_valid, key_code, key_held);
    end
    mask = 16'h0000;
    tick(95);
    vecs++;
    if (key_held !== 1'b1) begin
      errs++;
      $display("FAIL roll_release_early: got h=%b expected 1", key_held);
    end
    tick(1);
    vecs++;
    if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      errs++;
      $display("FAIL roll_release: got h=%b v=%b expected h=0 v=0", key_held, key_valid);
    end
    mask = 16'h0001;
    tick(95);
    vecs++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      errs++;
      $display("FAIL roll_repress_early: got v=%b h=%b expected v=0 h=0", key_valid, key_held);
    end
    tick(1);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd0, 1'b1}) begin
      errs++;
      $display("FAIL roll_repress: got v=%b code=%0d h=%b expected v=1 code=0 h=1",
               key_valid, key_code, key_held);
    end
    mask = 16'h8000;
    tick(95);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b0, 4'd0, 1'b1}) begin
      errs++;
      $display("FAIL roll_move_early: got v=%b code=%0d h=%b expected v=0 code=0 h=1",
               key_valid, key_code, key_held);
    end
    tick(1);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd15, 1'b1}) begin
      errs++;
      $display("FAIL roll_key15: got v=%b code=%0d h=%b expected v=1 code=15 h=1",
               key_valid, key_code, key_held);
    end
    tick(1);
    vecs++;
    if (pulses - base != 3) begin
      errs++;
      $display("FAIL roll_pulses: got %0d expected 3", pulses - base);
    end
  endtask

  task automatic test_ghost();
    mask = 16'h0020;
    do_reset();
    base = pulses;
    tick(96);
    vecs++;
    if ({key_valid, key_code} !== {1'b1, 4'd5}) begin
      errs++;
      $display("FAIL ghost_accept: got v=%b code=%0d expected v=1 code=5", key_valid, key_code);
    end
    mask = 16'h0060;
    tick(192);
    vecs++;
    if (pulses - base != 1 || key_code !== 4'd5 || key_held !== 1'b1 || key_valid !== 1'b0) begin
      errs++;
      $display("FAIL ghost_multi: got pulses=%0d code=%0d h=%b v=%b expected 1 5 1 0",
               pulses - base, key_code, key_held, key_valid);
    end
    mask = 16'h0020;
    tick(96);
    vecs++;
    if (key_valid !== 1'b0 || key_held !== 1'b1 || key_code !== 4'd5) begin
      errs++;
      $display("FAIL ghost_state: got v=%b h=%b code=%0d expected v=0 h=1 code=5",
               key_valid, key_held, key_code);
    end
    tick(1);
    vecs++;
    if (pulses - base != 1) begin
      errs++;
      $display("FAIL ghost_pulses: got %0d expected 1", pulses - base);
    end
  endtask

  task automatic test_async_reset_mid_press();
    mask = 16'h0200;
    do_reset();
    tick(96);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd9, 1'b1}) begin
      errs++;
      $display("FAIL arst_accept: got v=%b code=%0d h=%b expected v=1 code=9 h=1",
               key_valid, key_code, key_held);
    end
    tick(10);
    #3 rst = 1'b1;
    #1;
    vecs++;
    if ({row_out, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 2'b00}) begin
      errs++;
      $display("FAIL arst_clear: got row=%b code=%0d v=%b h=%b expected row=1110 code=0 v=0 h=0",
               row_out, key_code, key_valid, key_held);
    end
    @(negedge clk);
    rst = 1'b0;
    base = pulses;
    tick(95);
    vecs++;
    if (key_valid !== 1'b0 || key_held !== 1'b0 || pulses - base != 0) begin
      errs++;
      $display("FAIL arst_early: got v=%b h=%b pulses=%0d expected v=0 h=0 pulses=0",
               key_valid, key_held, pulses - base);
    end
    tick(1);
    vecs++;
    if ({key_valid, key_code, key_held} !== {1'b1, 4'd9, 1'b1}) begin
      errs++;
      $display("FAIL arst_repulse: got v=%b code=%0d h=%b expected v=1 code=9 h=1",
               key_valid, key_code, key_held);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_rollover();
    test_ghost();
    test_async_reset_mid_press();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
